// File: rtl/control_pkg.sv
// control_pkg: opcodes, ALU op encoding and control word shared by the decoder and its register.
package control_pkg;

    localparam int OPC_W   = 4;
    localparam int ALUOP_W = 3;

    localparam logic [OPC_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OPC_W-1:0] OP_MOV = 4'b0010;
    localparam logic [OPC_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OPC_W-1:0] OP_LW  = 4'b0110;
    localparam logic [OPC_W-1:0] OP_SW  = 4'b1000;
    localparam logic [OPC_W-1:0] OP_SHR = 4'b1010;
    localparam logic [OPC_W-1:0] OP_SHI = 4'b1011;
    localparam logic [OPC_W-1:0] OP_BNE = 4'b1100;
    localparam logic [OPC_W-1:0] OP_SET = 4'b1101;

    typedef enum logic [ALUOP_W-1:0] {
        ADD    = 3'd0,
        SUB    = 3'd1,
        XOR    = 3'd2,
        PASS_B = 3'd3,
        SHIFT  = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    branch;
        logic    mem_read;
        logic    mem_to_reg;
        logic    mem_write;
        logic    alu_src;
        logic    reg_write;
        alu_op_e alu_op;
        logic    illegal;
    } ctrl_t;

    localparam ctrl_t NOP = '0;

    // bits ordered RegDst Branch MemRead MemtoReg MemWrite ALUSrc RegWrite, as in the decode table
    function automatic ctrl_t mk(input logic [6:0] bits, input alu_op_e op);
        return ctrl_t'({bits, op, 1'b0});
    endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode to control word lookup.
module control_decode
    import control_pkg::*;
(
    input  logic [OPC_W-1:0] instr,
    output ctrl_t            ctrl
);

    // X/Z opcodes match no item and land in the illegal default
    always_comb begin
        ctrl = NOP;
        case (instr)
            OP_ADD:  ctrl = mk(7'b1000001, ADD);
            OP_MOV:  ctrl = mk(7'b1000001, PASS_B);
            OP_XOR:  ctrl = mk(7'b1000001, XOR);
            OP_LW:   ctrl = mk(7'b0011011, ADD);
            OP_SW:   ctrl = mk(7'b0000110, ADD);
            OP_SHR:  ctrl = mk(7'b1000001, SHIFT);
            OP_SHI:  ctrl = mk(7'b1000011, SHIFT);
            OP_BNE:  ctrl = mk(7'b0100000, SUB);
            OP_SET:  ctrl = mk(7'b0000011, PASS_B);
            default: ctrl = '{illegal: 1'b1, alu_op: ADD, default: 1'b0};
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: main decoder with one registered decode stage, async reset to NOP.
module control_unit
    import control_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OPC_W-1:0]   instr,
    output logic               RegDst,
    output logic               Branch,
    output logic               MemRead,
    output logic               MemtoReg,
    output logic               MemWrite,
    output logic               ALUSrc,
    output logic               RegWrite,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal
);

    ctrl_t d, q;

    control_decode u_decode (
        .instr(instr),
        .ctrl (d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= NOP;
        else       q <= d;
    end

    assign RegDst   = q.reg_dst;
    assign Branch   = q.branch;
    assign MemRead  = q.mem_read;
    assign MemtoReg = q.mem_to_reg;
    assign MemWrite = q.mem_write;
    assign ALUSrc   = q.alu_src;
    assign RegWrite = q.reg_write;
    assign alu_op   = q.alu_op;
    assign illegal  = q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of the registered opcode decoder, reset behaviour and invariants.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] instr = 4'b0110;
    logic       RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, illegal;
    logic [2:0] alu_op;

    int checks = 0;
    int failures = 0;

    control_unit dut (
        .clk(clk), .reset(reset), .instr(instr),
        .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .alu_op(alu_op), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {RegDst Branch MemRead MemtoReg MemWrite ALUSrc RegWrite, alu_op, illegal}
    function automatic logic [10:0] expect_of(input logic [3:0] op);
        case (op)
            4'b0000: return {7'b1000001, 3'd0, 1'b0};
            4'b0010: return {7'b1000001, 3'd3, 1'b0};
            4'b0100: return {7'b1000001, 3'd2, 1'b0};
            4'b0110: return {7'b0011011, 3'd0, 1'b0};
            4'b1000: return {7'b0000110, 3'd0, 1'b0};
            4'b1010: return {7'b1000001, 3'd4, 1'b0};
            4'b1011: return {7'b1000011, 3'd4, 1'b0};
            4'b1100: return {7'b0100000, 3'd1, 1'b0};
            4'b1101: return {7'b0000011, 3'd3, 1'b0};
            default: return {7'b0000000, 3'd0, 1'b1};
        endcase
    endfunction

    function automatic logic [10:0] observed();
        return {RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, alu_op, illegal};
    endfunction

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic invariants(input string tag);
        checks++;
        assert (!(MemRead && MemWrite) && !(MemtoReg && !MemRead) && !(Branch && (RegWrite || MemWrite))) else begin
            failures++;
            $error("FAIL inv_%s observed=%b expected=no_violation", tag, observed());
        end
    endtask

    task automatic step(input logic [3:0] op, input string tag);
        @(negedge clk);
        instr = op;
        @(posedge clk);
        #1;
        check(tag, observed(), expect_of(op));
        invariants(tag);
    endtask

    logic [3:0] seq [12] = '{4'b0110, 4'b1000, 4'b1101, 4'b1100, 4'b1100, 4'b0000,
                             4'b0010, 4'b0100, 4'b1010, 4'b1011, 4'b1011, 4'b1010};
    logic [3:0] bad [7] = '{4'b0001, 4'b0011, 4'b0101, 4'b0111, 4'b1001, 4'b1110, 4'b1111};

    initial begin
        #2;
        check("reset_nop", observed(), 11'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first_after_reset_lw", observed(), {7'b0011011, 3'd0, 1'b0});

        foreach (seq[i]) step(seq[i], $sformatf("seq%0d_op%b", i, seq[i]));
        step(4'b1000, "sw_again");
        check("sw_memwrite_regwrite", {9'b0, MemWrite, RegWrite}, 11'b10);
        step(4'b1011, "shi_again");
        check("shi_alusrc", {10'b0, ALUSrc}, 11'b1);

        foreach (bad[i]) step(bad[i], $sformatf("illegal_op%b", bad[i]));
        step(4'b0000, "add_after_illegal");

        step(4'b0110, "lw_before_pulse");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset_pulse", observed(), 11'b0);
        #1;
        reset = 1'b0;
        #1;
        check("no_reload_without_edge", observed(), 11'b0);
        @(posedge clk);
        #1;
        check("reload_after_pulse", observed(), expect_of(4'b0110));

        for (int k = 0; k < 16; k++) step(k[3:0], $sformatf("sweep_op%b", k[3:0]));

        @(negedge clk);
        instr = 4'b1100;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_bne%0d", k), observed(), {7'b0100000, 3'd1, 1'b0});
            invariants($sformatf("hold_bne%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
